// File: rtl/bp_probe_gen_if.sv
// bp_probe_gen_if -- BytePipe byte channel between a pipe endpoint and
// bp_probe_gen.
//   i_bp_data/i_bp_valid : upstream command/data byte into the generator
//   o_bp_ready           : generator accepts upstream byte
//   o_bp_data/o_bp_valid : response byte out of the generator
//   i_bp_ready           : downstream accepts response byte
// slave modport is the generator side, master is the pipe side.
interface bp_probe_gen_if;
  logic [7:0] i_bp_data;
  logic       i_bp_valid;
  logic       o_bp_ready;
  logic [7:0] o_bp_data;
  logic       o_bp_valid;
  logic       i_bp_ready;

  modport slave (
    input  i_bp_data, i_bp_valid, i_bp_ready,
    output o_bp_ready, o_bp_data, o_bp_valid
  );

  modport master (
    output i_bp_data, i_bp_valid, i_bp_ready,
    input  o_bp_ready, o_bp_data, o_bp_valid
  );
endinterface

// File: rtl/bp_probe_gen.sv
// bp_probe_gen -- BytePipe-controlled pseudo-random probe pulse generator.
// Each of N_PROBE channels owns a Galois LFSR and a density threshold; the
// channel pulses when the low DENSITY_W LFSR bits fall below the threshold.
//
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (overrides i_cg)
//   i_cg         : clock-gate enable, all state holds while low
//   bp           : BytePipe command/response channel (bp_probe_gen_if.slave)
//   o_probe      : registered probe pulses, one bit per channel
//
// Command format {rnw, addr[6:0]}; a write takes a second data byte, a read
// returns one response byte.
//   0x00..N_PROBE-1 density[i] RW
//   0x7E ctrl: bit0 enable, bit1 reseed (write-1 pulse, reads 0)
//   0x7F N_PROBE (RO)
// Optional build macro BP_PROBE_GEN_COUNT_EN adds per-channel 16-bit
// saturating pulse counters at 0x40+2i (low) / 0x41+2i (high snapshot).

// One probe channel: LFSR, density register, registered pulse and optional
// pulse counter.
module bp_probe_lane #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED_I    = 16'h0001,
  parameter int                DENSITY_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 cg,
  input  logic                 en,
  input  logic                 reseed,
  input  logic                 dens_we,
  input  logic [DENSITY_W-1:0] dens_wdata,
`ifdef BP_PROBE_GEN_COUNT_EN
  input  logic                 rd_lo,
  output logic [15:0]          cnt,
  output logic [7:0]           cnt_hi,
`endif
  output logic [DENSITY_W-1:0] density,
  output logic                 probe
);
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_step;

  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);

  // Probe uses the pre-step LFSR and the pre-write enable/density, so the
  // first pulse after enabling is evaluated on the seed value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr    <= SEED_I;
      density <= '0;
      probe   <= 1'b0;
    end else if (cg) begin
      if (dens_we) density <= dens_wdata;
      if (reseed)  lfsr <= SEED_I;
      else if (en) lfsr <= lfsr_step;
      probe <= en & (lfsr[DENSITY_W-1:0] < density);
    end
  end

`ifdef BP_PROBE_GEN_COUNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      cnt_hi <= '0;
    end else if (cg) begin
      if (reseed) begin
        cnt    <= '0;
        cnt_hi <= '0;
      end else begin
        if (probe && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        // Snapshot so the following high-byte read matches the low byte.
        if (rd_lo) cnt_hi <= cnt[15:8];
      end
    end
  end
`endif
endmodule

module bp_probe_gen #(
  parameter int                N_PROBE   = 4,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                DENSITY_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cg,
  bp_probe_gen_if.slave      bp,
  output logic [N_PROBE-1:0] o_probe
);
  localparam logic [6:0] A_CTRL = 7'h7E;
  localparam logic [6:0] A_ID   = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_WRDATA, S_RDRESP} state_t;

  state_t     state, state_nx;
  logic [6:0] addr_q;
  logic [7:0] rsp_data;
  logic       rsp_vld;
  logic       en;
  logic       in_xfer, out_xfer;
  logic       wr_en, rd_xfer;
  logic [7:0] rd_byte;
  logic       ctrl_we, reseed;

  logic [N_PROBE-1:0]                dens_we;
  logic [N_PROBE-1:0][DENSITY_W-1:0] density;
`ifdef BP_PROBE_GEN_COUNT_EN
  logic [N_PROBE-1:0]                rd_lo;
  logic [N_PROBE-1:0][15:0]          cnt;
  logic [N_PROBE-1:0][7:0]           cnt_hi;
`endif

  // Handshakes are masked by the clock gate so nothing transfers while held.
  assign bp.o_bp_ready = i_cg & (state != S_RDRESP);
  assign bp.o_bp_valid = i_cg & rsp_vld;
  assign bp.o_bp_data  = rsp_data;
  assign in_xfer       = bp.i_bp_valid & bp.o_bp_ready;
  assign out_xfer      = bp.o_bp_valid & bp.i_bp_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst)     state <= S_IDLE;
    else if (i_cg) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    rd_xfer  = 1'b0;
    case (state)
      S_IDLE: if (in_xfer) begin
        if (bp.i_bp_data[7]) begin
          rd_xfer  = 1'b1;
          state_nx = S_RDRESP;
        end else begin
          state_nx = S_WRDATA;
        end
      end
      S_WRDATA: if (in_xfer) begin
        wr_en    = 1'b1;
        state_nx = S_IDLE;
      end
      S_RDRESP: if (out_xfer) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Read mux decodes the command byte directly so the response is valid
  // one cycle after the command transfer.
  always_comb begin
    rd_byte = '0;
    if (bp.i_bp_data[6:0] == A_CTRL)    rd_byte = {7'd0, en};
    else if (bp.i_bp_data[6:0] == A_ID) rd_byte = 8'(N_PROBE);
    else begin
      for (int i = 0; i < N_PROBE; i++) begin
        if (bp.i_bp_data[6:0] == 7'(i)) rd_byte = 8'(density[i]);
`ifdef BP_PROBE_GEN_COUNT_EN
        if (bp.i_bp_data[6:0] == 7'(64 + 2*i))     rd_byte = cnt[i][7:0];
        if (bp.i_bp_data[6:0] == 7'(64 + 2*i + 1)) rd_byte = cnt_hi[i];
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q   <= '0;
      rsp_data <= '0;
      rsp_vld  <= 1'b0;
    end else if (i_cg) begin
      if (state == S_IDLE && in_xfer) addr_q <= bp.i_bp_data[6:0];
      if (rd_xfer) begin
        rsp_data <= rd_byte;
        rsp_vld  <= 1'b1;
      end else if (out_xfer) begin
        rsp_vld  <= 1'b0;
      end
    end
  end

  assign ctrl_we = wr_en & (addr_q == A_CTRL);
  assign reseed  = ctrl_we & bp.i_bp_data[1];

  always_ff @(posedge i_clk) begin
    if (i_rst)        en <= 1'b0;
    else if (ctrl_we) en <= bp.i_bp_data[0];
  end

  for (genvar i = 0; i < N_PROBE; i++) begin : g_lane
    localparam logic [LFSR_W-1:0] S_RAW  = SEED ^ LFSR_W'(i + 1);
    localparam logic [LFSR_W-1:0] SEED_I = (S_RAW == '0) ? LFSR_W'(1) : S_RAW;

    assign dens_we[i] = wr_en & (addr_q == 7'(i));
`ifdef BP_PROBE_GEN_COUNT_EN
    assign rd_lo[i]   = rd_xfer & (bp.i_bp_data[6:0] == 7'(64 + 2*i));
`endif

    bp_probe_lane #(
      .LFSR_W    (LFSR_W),
      .LFSR_TAPS (LFSR_TAPS),
      .SEED_I    (SEED_I),
      .DENSITY_W (DENSITY_W)
    ) u_lane (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .cg         (i_cg),
      .en         (en),
      .reseed     (reseed),
      .dens_we    (dens_we[i]),
      .dens_wdata (bp.i_bp_data[DENSITY_W-1:0]),
`ifdef BP_PROBE_GEN_COUNT_EN
      .rd_lo      (rd_lo[i]),
      .cnt        (cnt[i]),
      .cnt_hi     (cnt_hi[i]),
`endif
      .density    (density[i]),
      .probe      (o_probe[i])
    );
  end
endmodule

// File: doc/bp_probe_gen.md
Name: bp_probe_gen

Overview:
- Synthesisable, BytePipe-controlled pseudo-random probe stimulus generator. It is the next generation of the `$random` probe driver used around correlator benches.
- Drives `N_PROBE` pulse channels; each channel's pulse density is set at runtime by a register.
- Uses per-channel Galois LFSRs, so identical stimulus is reproducible in both simulation and FPGA.
- Sits between a ptyBytePipe/usbfsBytePipe and the `i_probe` input of bpCorrelator.

Parameters:
- `N_PROBE`, 4, number of probe channels (1..32).
- `LFSR_W`, 16, width of each channel LFSR (≥ `DENSITY_W`).
- `LFSR_TAPS`, 16'hB400, Galois feedback mask for width `LFSR_W`.
- `SEED`, 16'hACE1, base seed. Channel i seed = `SEED ^ (i+1)`; a zero result is replaced by 1.
- `DENSITY_W`, 8, width of each density threshold.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_cg`  in  1  clock-gate enable; when 0, all state holds.
- `i_bp_data`  in  8  upstream command byte.
- `i_bp_valid`  in  1  upstream byte valid.
- `o_bp_ready`  out  1  upstream ready.
- `o_bp_data`  out  8  downstream response byte.
- `o_bp_valid`  out  1  downstream valid.
- `i_bp_ready`  in  1  downstream ready.
- `o_probe`  out  `N_PROBE`  registered probe pulses.

Behaviour:
- Reset (sync, `i_rst`=1 at a posedge) applies regardless of `i_cg`:
  - `o_probe`=0, `o_bp_valid`=0, `o_bp_data`=0.
  - All densities=0, ctrl.enable=0, LFSRs=seeds, FSM=IDLE.
- Byte transfer: occurs on a posedge where valid & ready & `i_cg`. `o_bp_ready`/`o_bp_valid` are forced 0 while `i_cg`=0.
- Command byte format: `{rnw[7], addr[6:0]}`.
- Register map:
  - addr i < `N_PROBE`: density[i], RW.
  - 0x7E: ctrl, RW. bit0 enable; bit1 reseed (write-1 pulse, reads 0).
  - 0x7F: RO, value `N_PROBE`.
  - Unmapped: reads 0, writes ignored.
- FSM IDLE (`o_bp_ready`=1):
  - On transfer, latch addr.
  - If rnw=0, go to WRDATA.
  - If rnw=1, load `o_bp_data`=reg[addr], `o_bp_valid`=1, go to RDRESP.
- FSM WRDATA (`o_bp_ready`=1): on transfer, write reg[addr]=byte, go to IDLE. The write takes effect in the next cycle.
- FSM RDRESP (`o_bp_ready`=0): hold `o_bp_data` stable until a downstream transfer, then `o_bp_valid`=0 and go to IDLE. There is no pipelining of a second command; read latency is 1 cycle from the command transfer to valid.
- LFSR stepping: each LFSR steps on every posedge with `i_cg` & enable.
  - Galois step: `lfsr = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0)`.
  - LFSRs hold while disabled.
- Probe output: `o_probe[i]` (registered, next cycle) = `i_cg` & enable & (`lfsr_i[DENSITY_W-1:0]` < density[i]).
  - density 0 means never pulses; max density gives (2^`DENSITY_W`−1)/2^`DENSITY_W`.
  - When `i_cg`=0, `o_probe` holds its value.
- Reseed write: reloads all LFSRs with seeds in the same cycle the write takes effect. It overrides that cycle's step.
- Disable write (enable 1→0): `o_probe` clears on the next enabled-`i_cg` posedge.
- Reset mid-command: a partial command is discarded and a pending read response is dropped.

Optional Feature:
- Macro: `BP_PROBE_GEN_COUNT_EN`.
- When defined:
  - Each channel has a 16-bit saturating counter of asserted `o_probe[i]` cycles.
  - Readable at 0x40+2i (low byte) and 0x41+2i (high byte).
  - Reading the low byte snapshots the high byte, so a following high-byte read returns a coherent value.
  - Counters clear on reset or reseed.
- When undefined: those addresses read 0 and no counter logic exists.

Test Plan:
- Reset, then read 0x7F → response 0x04. Read 0x00 → 0x00. `o_probe`=0 for 100 cycles.
- Write density[0]=0xFF, density[1]=0x00, ctrl=0x01; run 10000 cycles.
  - Channel 0 pulse count is within 9960±40.
  - Channel 1 pulse count is 0.
- Enable with density[2]=0x80 and record 64 cycles of `o_probe[2]`. Write ctrl=0x03 (reseed+enable) and record 64 cycles again → the two sequences are identical.
- Issue a read of 0x00 with `i_bp_ready` held 0 for 20 cycles:
  - `o_bp_valid`=1 and data stable throughout.
  - `o_bp_ready`=0 throughout.
  - After ready rises, one transfer completes and the FSM returns to IDLE.
- Toggle `i_cg` low 1 cycle in 4 while enabled:
  - LFSR sequence equals the ungated sequence with the gated cycles removed.
  - No byte is lost or duplicated across 50 random writes with read-back.
- With `BP_PROBE_GEN_COUNT_EN`: density[3]=0xFF, enable 300 cycles, disable; read 0x46/0x47 → count in 295..300. Reseed → 0x0000.
